// File: rtl/display_streamer.sv
// display_streamer: keeps a shadow copy of the CPU display window by snooping
// data-memory writes. Each dsp pulse streams the window out as a byte stream
// over a valid/ready handshake.
//
// Optional feature macro: ASCII_DSP_EN
//   defined   : non-printable bytes become '.', a 0x0A follows every
//               LINE_BYTES data bytes, and the frame ends on that 0x0A
//   undefined : raw shadow bytes, DEPTH bytes per frame
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  CPU memory write port (snooped)
//   dsp                 display trigger
//   out_valid/out_ready/out_data/out_last  byte stream
//   busy                frame in progress or pending
module display_streamer #(
  parameter logic [7:0]  BASE_ADDR  = 8'h80,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned LINE_BYTES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       dsp,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [8:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [8:0] WIN_HI = 9'(32'(BASE_ADDR) + DEPTH);

  // Reject parameter sets the frame logic cannot honour.
  if (DEPTH == 0 || LINE_BYTES == 0 || (DEPTH % LINE_BYTES) != 0 ||
      (32'(BASE_ADDR) + DEPTH) > 256) begin : g_bad_cfg
    $error("display_streamer: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_NL   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             frame_done;
  logic [7:0]       shadow_q [DEPTH];

  logic             wr_hit;
  logic [IDX_W-1:0] wr_off;
  logic [7:0]       byte_sel;
  logic             valid_d, last_d, busy_d;
  logic [7:0]       data_d;

`ifdef ASCII_DSP_EN
  localparam int unsigned COL_W = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_BYTES - 1);

  logic [COL_W-1:0] col_q, col_d;

  // Printable ASCII passes through, everything else shows as '.'.
  function automatic logic [7:0] printable(input logic [7:0] b);
    return (b >= 8'h20 && b <= 8'h7E) ? b : 8'h2E;
  endfunction
`endif

  // Window hit decode; 9-bit compare so BASE_ADDR+DEPTH=256 works.
  assign wr_hit = wr_en && ({1'b0, wr_addr} >= WIN_LO) && ({1'b0, wr_addr} < WIN_HI);
  assign wr_off = IDX_W'(wr_addr - BASE_ADDR);

  // Shadow window, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) shadow_q[i] <= 8'h00;
    end else if (wr_hit) begin
      shadow_q[wr_off] <= wr_data;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
`ifdef ASCII_DSP_EN
      col_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_last  <= last_d;
      busy      <= busy_d;
`ifdef ASCII_DSP_EN
      col_q     <= col_d;
`endif
    end
  end

  // Next-state logic and next output values.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    frame_done = 1'b0;
`ifdef ASCII_DSP_EN
    col_d      = col_q;
`endif

    case (state_q)
      S_IDLE: begin
        // pending can be set here by a dsp that hit the completion edge
        if (dsp || pending_q) begin
          state_d   = S_SEND;
          idx_d     = '0;
          pending_d = 1'b0;
`ifdef ASCII_DSP_EN
          col_d     = '0;
`endif
        end
      end
      S_SEND: begin
        pending_d = pending_q | dsp;
        if (out_ready) begin
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
`ifdef ASCII_DSP_EN
          if (col_q == COL_LAST) begin
            state_d = S_NL;
            col_d   = '0;
          end else begin
            col_d = col_q + COL_W'(1);
          end
`else
          if (idx_q == LAST_IDX) frame_done = 1'b1;
`endif
        end
      end
`ifdef ASCII_DSP_EN
      S_NL: begin
        pending_d = pending_q | dsp;
        if (out_ready) begin
          // idx has already wrapped to 0 after the last data byte
          if (idx_q == '0) frame_done = 1'b1;
          else             state_d = S_SEND;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Frame completion: chain straight into the next frame if one is pending.
    if (frame_done) begin
      idx_d     = '0;
      pending_d = dsp;
      state_d   = pending_q ? S_SEND : S_IDLE;
`ifdef ASCII_DSP_EN
      col_d     = '0;
`endif
    end

    // Forward a same-edge write so the presented byte is never stale.
    byte_sel = (wr_hit && wr_off == idx_d) ? wr_data : shadow_q[idx_d];

    valid_d = (state_d != S_IDLE);
    busy_d  = valid_d | pending_d;
    data_d  = 8'h00;
    last_d  = 1'b0;
    if (state_d == S_SEND) begin
`ifdef ASCII_DSP_EN
      data_d = printable(byte_sel);
`else
      data_d = byte_sel;
      last_d = (idx_d == LAST_IDX);
`endif
    end
`ifdef ASCII_DSP_EN
    else if (state_d == S_NL) begin
      data_d = 8'h0A;
      last_d = (idx_d == '0);
    end
`endif
  end

endmodule

// File: tb/tb_display_streamer.sv
// Scoreboard bench for display_streamer: stimulus pushes expected frames,
// a negedge monitor pops and compares every accepted byte.
module tb_display_streamer;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned LB    = 8;
`ifdef ASCII_DSP_EN
  localparam int FL = DEPTH + DEPTH / LB;
`else
  localparam int FL = DEPTH;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       dsp = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid, out_last, busy;
  logic [7:0] out_data;

  int tests = 0;
  int fails = 0;
  logic [7:0] model [DEPTH];
  logic [8:0] sb [$];

  display_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .dsp       (dsp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Push the first n bytes of the expected frame built from model[].
  task automatic push_frame(input int n);
    int k;
    k = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [7:0] b;
      logic       lst;
      b = model[i];
`ifdef ASCII_DSP_EN
      if (b < 8'h20 || b > 8'h7E) b = 8'h2E;
      lst = 1'b0;
`else
      lst = (i == int'(DEPTH) - 1);
`endif
      if (k < n) sb.push_back({lst, b});
      k++;
`ifdef ASCII_DSP_EN
      if (i % int'(LB) == int'(LB) - 1) begin
        if (k < n) sb.push_back({(i == int'(DEPTH) - 1), 8'h0A});
        k++;
      end
`endif
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Clock through a frame (dsp already raised); optional extra dsp pulses,
  // a mid-frame write pair, ready toggling, or an early stop.
  task automatic run(input bit toggle, input int d1, input int d2, input int wc,
                     input int stop, output int cycles);
    cycles = 0;
    forever begin
      @(posedge clk);
      cycles++;
      #1;
      dsp = (cycles == d1) || (cycles == d2);
      if (toggle) out_ready = ~out_ready;
      wr_en   = (cycles == wc) || (cycles == wc + 1);
      wr_addr = (cycles == wc) ? 8'hFF : 8'h80;
      wr_data = (cycles == wc) ? 8'h41 : 8'h42;
      if (cycles == stop) break;
      if (!busy) break;
      if (cycles > 4 * FL) begin
        check("frame_timeout", 32'(cycles), 32'(4 * FL));
        break;
      end
    end
  endtask

  // Monitor: compare every accepted byte, and hold-stability during stalls.
  logic       stalled = 1'b0;
  logic [8:0] held = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid) check("stall_hold", {out_last, out_data}, held);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got 0x%0h, expected none", {out_last, out_data});
        end else begin
          check("stream_byte", {out_last, out_data}, sb.pop_front());
        end
      end
      stalled = out_valid && !out_ready;
      held    = {out_last, out_data};
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time %0t, expected finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int idle_valid;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data",  32'(out_data),  0);
    check("rst_last",  32'(out_last),  0);
    check("rst_busy",  32'(busy),      0);
    @(posedge clk); #1;

    // Empty-window frame at full rate.
    push_frame(FL);
    dsp = 1'b1;
    run(1'b0, -1, -1, -1, -1, cyc);
    check("t1_cycles", 32'(cyc), 32'(FL + 1));

    // In-window writes appear, out-of-window write ignored.
    wr(8'h80, 8'h48);
    wr(8'h81, 8'h69);
    wr(8'h7F, 8'h55);
    model[0] = 8'h48;
    model[1] = 8'h69;
    push_frame(FL);
    dsp = 1'b1;
    run(1'b0, -1, -1, -1, -1, cyc);
    check("t2_cycles", 32'(cyc), 32'(FL + 1));

    // out_ready toggling: twice as long, no loss or duplication.
    push_frame(FL);
    dsp = 1'b1;
    out_ready = 1'b0;
    run(1'b1, -1, -1, -1, -1, cyc);
    out_ready = 1'b1;
    check("t3_cycles", 32'(cyc), 32'(2 * FL));

    // Extra dsp pulses merge into exactly one back-to-back frame.
    push_frame(FL);
    push_frame(FL);
    dsp = 1'b1;
    run(1'b0, 40, 60, -1, -1, cyc);
    check("t4_cycles", 32'(cyc), 32'(2 * FL + 1));
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_third_valid", 32'(out_valid), 0);
    check("t4_no_third_busy",  32'(busy),      0);

    // Live stream: write ahead of the pointer shows, behind it does not.
    model[127] = 8'h41;
    push_frame(FL);
    model[0] = 8'h42;
    dsp = 1'b1;
    run(1'b0, -1, -1, 60, -1, cyc);
    check("t5_cycles", 32'(cyc), 32'(FL + 1));

    // Reset mid-frame after 49 accepted bytes.
    push_frame(49);
    dsp = 1'b1;
    run(1'b0, -1, -1, -1, 50, cyc);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_last",  32'(out_last),  0);
    check("t6_rst_busy",  32'(busy),      0);
    check("t6_sb_drained", 32'(sb.size()), 0);
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h00;
    @(posedge clk); #1 rst_n = 1'b1;
    idle_valid = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || busy) idle_valid++;
    end
    check("t6_idle_after_rst", 32'(idle_valid), 0);
    @(posedge clk); #1;
    push_frame(FL);
    dsp = 1'b1;
    run(1'b0, -1, -1, -1, -1, cyc);
    check("t6_cycles", 32'(cyc), 32'(FL + 1));

    repeat (2) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
